// File: rtl/cpu_defs.sv
// Shared definitions for the decode-stage hazard/forwarding logic.
package cpu_defs;

    // Architectural register address width (32 registers, r0 hard-wired to zero).
    localparam int REG_AW = 5;

    // Operand source encoding reported on fwd_sel1/fwd_sel2.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    // One in-flight register write tracked per pipeline slot.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] waddr;
        logic              load;
    } slot_t;

    // A slot supplies a read port when the port is enabled, the slot holds a
    // live write to the same register, and that register is not r0.
    function automatic logic slot_hit(slot_t s, logic re, logic [REG_AW-1:0] raddr);
        return re & s.valid & (s.waddr == raddr) & (raddr != '0);
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: operand requests, register
// file data, result buses, pipeline controls and the resolved operands.
interface id_hazard_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
);
    logic          id_valid;
    logic          id_re1;
    logic [AW-1:0] id_raddr1;
    logic          id_re2;
    logic [AW-1:0] id_raddr2;
    logic          id_we;
    logic [AW-1:0] id_waddr;
    logic          id_load;
    logic [DW-1:0] reg_data1;
    logic [DW-1:0] reg_data2;
    logic [DW-1:0] ex_wdata;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] wb_wdata;
    logic          ex_busy;
    logic          flush;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [1:0]    fwd_sel1;
    logic [1:0]    fwd_sel2;
    logic          stall_id;
    logic          issue;
    logic [CW-1:0] bubble_cnt;

    // Pipeline side: drives decode state and result buses, consumes operands.
    modport master (
        output id_valid, id_re1, id_raddr1, id_re2, id_raddr2,
        output id_we, id_waddr, id_load,
        output reg_data1, reg_data2, ex_wdata, mem_wdata, wb_wdata,
        output ex_busy, flush,
        input  fwd_data1, fwd_data2, fwd_sel1, fwd_sel2,
        input  stall_id, issue, bubble_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_re1, id_raddr1, id_re2, id_raddr2,
        input  id_we, id_waddr, id_load,
        input  reg_data1, reg_data2, ex_wdata, mem_wdata, wb_wdata,
        input  ex_busy, flush,
        output fwd_data1, fwd_data2, fwd_sel1, fwd_sel2,
        output stall_id, issue, bubble_cnt
    );
endinterface

// File: rtl/fwd_mux.sv
// Per-port operand selector: youngest matching writer wins (EX > MEM > WB),
// otherwise the register file value passes through.
module fwd_mux
    import cpu_defs::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    match,     // {EX, MEM, WB} hits for this port
    input  logic [DW-1:0] reg_data,
    input  logic [DW-1:0] ex_data,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_data,
    output fwd_sel_t      sel,
    output logic [DW-1:0] data
);

    // Priority select of the operand source.
    always_comb begin
        // NOTE: defaults first so every path assigns sel/data and no latch is inferred.
        sel  = FWD_REG;
        data = reg_data;
        if (match[2]) begin
            sel  = FWD_EX;
            data = ex_data;
        end else if (match[1]) begin
            sel  = FWD_MEM;
            data = mem_data;
        end else if (match[0]) begin
            sel  = FWD_WB;
            data = wb_data;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage scoreboard: tracks writes in EX/MEM/WB, forwards operands,
// stalls on load-use and freezes while EX runs a multi-cycle operation.
// The slot record is sized by cpu_defs::REG_AW, so AW must equal it.
module id_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int DW = 32,
    parameter int AW = REG_AW,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_hazard_ctrl_if.slave  bus
);

    slot_t         ex_q, mem_q, wb_q;
    logic [CW-1:0] bubble_q;

    logic [2:0]    match1, match2;
    fwd_sel_t      sel1, sel2;
    logic [DW-1:0] data1, data2;
    logic          load_use;
    logic          stall;
    logic          issue_int;
    logic [AW-1:0] raddr1, raddr2;

    assign raddr1 = bus.id_raddr1;
    assign raddr2 = bus.id_raddr2;

    // Per-port hit vectors against the three in-flight slots.
    always_comb begin
        match1 = {slot_hit(ex_q,  bus.id_re1, raddr1),
                  slot_hit(mem_q, bus.id_re1, raddr1),
                  slot_hit(wb_q,  bus.id_re1, raddr1)};
        match2 = {slot_hit(ex_q,  bus.id_re2, raddr2),
                  slot_hit(mem_q, bus.id_re2, raddr2),
                  slot_hit(wb_q,  bus.id_re2, raddr2)};
    end

    fwd_mux #(.DW(DW)) u_fwd1 (
        .match    (match1),
        .reg_data (bus.reg_data1),
        .ex_data  (bus.ex_wdata),
        .mem_data (bus.mem_wdata),
        .wb_data  (bus.wb_wdata),
        .sel      (sel1),
        .data     (data1)
    );

    fwd_mux #(.DW(DW)) u_fwd2 (
        .match    (match2),
        .reg_data (bus.reg_data2),
        .ex_data  (bus.ex_wdata),
        .mem_data (bus.mem_wdata),
        .wb_data  (bus.wb_wdata),
        .sel      (sel2),
        .data     (data2)
    );

    // A load in EX cannot forward yet: its consumer must wait one cycle.
    assign load_use  = bus.id_valid & ex_q.valid & ex_q.load & (match1[2] | match2[2]);
    assign stall     = load_use | bus.ex_busy;
    assign issue_int = bus.id_valid & ~stall & ~bus.flush;

    // Everything visible is forced to zero while reset is held.
    assign bus.fwd_data1  = rst ? '0 : data1;
    assign bus.fwd_data2  = rst ? '0 : data2;
    assign bus.fwd_sel1   = rst ? 2'b00 : sel1;
    assign bus.fwd_sel2   = rst ? 2'b00 : sel2;
    assign bus.stall_id   = rst ? 1'b0 : stall;
    assign bus.issue      = rst ? 1'b0 : issue_int;
    assign bus.bubble_cnt = rst ? '0 : bubble_q;

    // Slot shift and bubble counting; everything holds while EX is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            bubble_q <= '0;
        end else if (!bus.ex_busy) begin
            // NOTE: non-blocking so MEM takes the old EX and WB the old MEM in one edge.
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= '{valid: issue_int & bus.id_we & (bus.id_waddr != '0),
                       waddr: bus.id_waddr,
                       load:  bus.id_load};
            if (load_use && !bus.flush && bubble_q != '1)
                bubble_q <= bubble_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against an age-ordered queue model.
module tb_id_hazard_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;                       // narrow counter so saturation is reachable
    localparam int BMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    id_hazard_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: in-flight writers ordered by age, index 0 = youngest (EX).
    typedef struct {
        bit            v;
        logic [AW-1:0] a;
        bit            l;
    } ent_t;

    ent_t pipe[$];
    int   bubbles;

    int n_cmp = 0;
    int n_bad = 0;

    // Expectations for the current cycle, filled by evaluate().
    int            e_sel1, e_sel2;
    logic [DW-1:0] e_d1, e_d2;
    bit            e_lu, e_stall, e_issue;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        pipe = {};
        repeat (3) pipe.push_back('{v: 1'b0, a: '0, l: 1'b0});
        bubbles = 0;
    endtask

    function automatic void resolve(input bit re, input logic [AW-1:0] a,
                                    input logic [DW-1:0] rd,
                                    output int sel, output logic [DW-1:0] d);
        logic [DW-1:0] res [3];
        res[0] = bus.ex_wdata;
        res[1] = bus.mem_wdata;
        res[2] = bus.wb_wdata;
        sel = 0;
        d   = rd;
        if (re && a != '0) begin
            for (int age = 0; age < 3; age++) begin
                if (pipe[age].v && pipe[age].a == a) begin
                    sel = age + 1;
                    d   = res[age];
                    break;
                end
            end
        end
    endfunction

    // Sample outputs mid-cycle and compare them with the model.
    task automatic evaluate();
        @(negedge clk);
        resolve(bus.id_re1, bus.id_raddr1, bus.reg_data1, e_sel1, e_d1);
        resolve(bus.id_re2, bus.id_raddr2, bus.reg_data2, e_sel2, e_d2);
        e_lu    = bus.id_valid && pipe[0].l && (e_sel1 == 1 || e_sel2 == 1);
        e_stall = e_lu || bus.ex_busy;
        e_issue = bus.id_valid && !e_stall && !bus.flush;
        if (rst) begin
            check("rst_sel1",  bus.fwd_sel1, 0);
            check("rst_sel2",  bus.fwd_sel2, 0);
            check("rst_data1", bus.fwd_data1, 0);
            check("rst_data2", bus.fwd_data2, 0);
            check("rst_stall", bus.stall_id, 0);
            check("rst_issue", bus.issue, 0);
            check("rst_bcnt",  bus.bubble_cnt, 0);
        end else begin
            check("sel1",  bus.fwd_sel1, e_sel1);
            check("sel2",  bus.fwd_sel2, e_sel2);
            check("data1", bus.fwd_data1, e_d1);
            check("data2", bus.fwd_data2, e_d2);
            check("stall", bus.stall_id, e_stall);
            check("issue", bus.issue, e_issue);
            check("bcnt",  bus.bubble_cnt, bubbles);
        end
    endtask

    // Apply the clock edge to the model, then move past the DUT edge.
    task automatic advance();
        ent_t n;
        if (rst) begin
            model_clear();
        end else if (!bus.ex_busy) begin
            n.v = e_issue && bus.id_we && bus.id_waddr != '0;
            n.a = bus.id_waddr;
            n.l = bus.id_load;
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (e_lu && !bus.flush && bubbles < BMAX) bubbles++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        evaluate();
        advance();
    endtask

    task automatic instr(input bit v, input bit re1, input int a1, input bit re2, input int a2,
                         input bit we, input int wa, input bit ld);
        bus.id_valid  = v;
        bus.id_re1    = re1;
        bus.id_raddr1 = AW'(a1);
        bus.id_re2    = re2;
        bus.id_raddr2 = AW'(a2);
        bus.id_we     = we;
        bus.id_waddr  = AW'(wa);
        bus.id_load   = ld;
    endtask

    task automatic rand_data();
        bus.reg_data1 = $urandom;
        bus.reg_data2 = $urandom;
        bus.ex_wdata  = $urandom;
        bus.mem_wdata = $urandom;
        bus.wb_wdata  = $urandom;
    endtask

    initial begin
        model_clear();
        rst         = 1'b1;
        bus.ex_busy = 1'b0;
        bus.flush   = 1'b0;
        instr(1, 1, 1, 1, 2, 1, 1, 0);
        rand_data();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // EX forwarding: ori r1 then read r1.
        instr(1, 0, 0, 0, 0, 1, 1, 0);
        cycle();
        instr(1, 1, 1, 0, 0, 0, 0, 0);
        bus.ex_wdata = 32'h1234;
        evaluate();
        check("ex_fwd_sel",   bus.fwd_sel1, 1);
        check("ex_fwd_data",  bus.fwd_data1, 32'h1234);
        check("ex_fwd_stall", bus.stall_id, 0);
        advance();

        // r2 in both MEM and WB: MEM wins, then WB once MEM drains.
        instr(1, 0, 0, 0, 0, 1, 2, 0);
        cycle();
        cycle();
        instr(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        instr(1, 0, 0, 1, 2, 0, 0, 0);
        bus.mem_wdata = 32'hA;
        bus.wb_wdata  = 32'hB;
        evaluate();
        check("mem_fwd_sel",  bus.fwd_sel2, 2);
        check("mem_fwd_data", bus.fwd_data2, 32'hA);
        advance();
        evaluate();
        check("wb_fwd_sel",  bus.fwd_sel2, 3);
        check("wb_fwd_data", bus.fwd_data2, 32'hB);
        advance();

        // Load-use on r3: one stall, one bubble, then MEM forwarding.
        instr(1, 0, 0, 0, 0, 1, 3, 1);
        cycle();
        instr(1, 1, 3, 0, 0, 0, 0, 0);
        evaluate();
        check("lu_stall", bus.stall_id, 1);
        check("lu_issue", bus.issue, 0);
        check("lu_bcnt0", bus.bubble_cnt, 0);
        advance();
        evaluate();
        check("lu_bcnt1", bus.bubble_cnt, 1);
        check("lu_sel",   bus.fwd_sel1, 2);
        check("lu_stall2", bus.stall_id, 0);
        advance();

        // Writes to r0 are never forwarded.
        instr(1, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        instr(1, 1, 0, 1, 0, 0, 0, 0);
        evaluate();
        check("r0_sel1",  bus.fwd_sel1, 0);
        check("r0_data1", bus.fwd_data1, bus.reg_data1 === e_d1 ? e_d1 : ~e_d1);
        check("r0_sel2",  bus.fwd_sel2, 0);
        advance();

        // ex_busy freeze with r5 in EX and decode reading r5.
        instr(1, 0, 0, 0, 0, 1, 5, 0);
        cycle();
        instr(1, 1, 5, 0, 0, 0, 0, 0);
        bus.ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            evaluate();
            check("busy_stall", bus.stall_id, 1);
            check("busy_sel",   bus.fwd_sel1, 1);
            advance();
        end
        bus.ex_busy = 1'b0;
        evaluate();
        check("busy_rel_issue", bus.issue, 1);
        advance();
        evaluate();
        check("busy_shift_sel", bus.fwd_sel1, 2);
        advance();

        // Load-use together with flush: no bubble counted.
        instr(1, 0, 0, 0, 0, 1, 3, 1);
        cycle();
        instr(1, 1, 3, 0, 0, 0, 0, 0);
        bus.flush = 1'b1;
        evaluate();
        check("flush_stall", bus.stall_id, 1);
        advance();
        bus.flush = 1'b0;
        evaluate();
        check("flush_bcnt", bus.bubble_cnt, 1);
        advance();

        // Back-to-back "ld r3,(r3)" drives the counter into saturation.
        instr(1, 1, 3, 0, 0, 1, 3, 1);
        for (int i = 0; i < 2 * BMAX + 8; i++) cycle();
        evaluate();
        check("sat_bcnt", bus.bubble_cnt, BMAX);
        advance();

        // Reset in the middle of a load-use stall.
        instr(1, 0, 0, 0, 0, 1, 3, 1);
        cycle();
        instr(1, 1, 3, 0, 0, 0, 0, 0);
        evaluate();
        check("rst_mid_stall", bus.stall_id, 1);
        advance();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        evaluate();
        check("rst_mid_sel",  bus.fwd_sel1, 0);
        check("rst_mid_bcnt", bus.bubble_cnt, 0);
        advance();

        // Randomized traffic over a small register window to provoke hits.
        for (int i = 0; i < 3000; i++) begin
            instr($urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 2) == 0);
            rand_data();
            bus.ex_busy = $urandom_range(0, 9) == 0;
            bus.flush   = $urandom_range(0, 9) == 0;
            rst         = $urandom_range(0, 199) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Scoreboard and forwarding controller for the decode stage's two register read ports.
- Tracks in-flight register writes in the EX, MEM and WB slots.
- Selects forwarded operand data in place of stale register-file data.
- Raises a decode stall on load-use hazards and holds the slot pipeline while EX is busy with a multi-cycle operation.
- Sits between the decode stage, the register file read ports and the EX/MEM/WB result buses. Decode consumes fwd_data1/fwd_data2 in place of reg_data1/reg_data2.

Parameters:
- DW, 32, operand and result data width
- AW, 5, register address width
- CW, 16, width of the load-use bubble counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_re1  in  1  read port 1 enable (from decode)
- id_raddr1  in  AW  read port 1 address
- id_re2  in  1  read port 2 enable
- id_raddr2  in  AW  read port 2 address
- id_we  in  1  decoded instruction writes a register
- id_waddr  in  AW  destination register
- id_load  in  1  decoded instruction is a load (result available only at MEM)
- reg_data1  in  DW  register file port 1 data
- reg_data2  in  DW  register file port 2 data
- ex_wdata  in  DW  EX-stage result
- mem_wdata  in  DW  MEM-stage result (includes load data)
- wb_wdata  in  DW  WB-stage result
- ex_busy  in  1  EX is executing a multi-cycle op; freeze pipeline
- flush  in  1  kill the instruction currently in decode
- fwd_data1  out  DW  resolved operand for port 1
- fwd_data2  out  DW  resolved operand for port 2
- fwd_sel1  out  2  source for port 1: 0 regfile, 1 EX, 2 MEM, 3 WB
- fwd_sel2  out  2  source for port 2 (same encoding)
- stall_id  out  1  hold PC/IF/ID this cycle
- issue  out  1  decode instruction advances into EX this cycle
- bubble_cnt  out  CW  saturating count of load-use bubbles inserted

Behaviour:
- Slot state: three registered entries EX, MEM, WB, each holding {valid, waddr, load}. Reset clears all valid bits and clears bubble_cnt to 0.
- While rst=1, all outputs are 0, including fwd_data*, fwd_sel*, stall_id, issue and bubble_cnt.
- Match rule for port n:
  - match_S = id_ren & S.valid & (S.waddr == id_raddrn) & (id_raddrn != 0).
  - Register 0 never matches.
- Forward priority is EX > MEM > WB > regfile. The youngest writer wins.
  - fwd_seln and fwd_datan are combinational from the current slots and inputs, with zero added latency.
  - If id_ren = 0: fwd_seln = 0 and fwd_datan = reg_datan.
- Load-use hazard:
  - Condition: id_valid & EX.valid & EX.load & (match_EX on either enabled port).
  - Effect: stall_id = 1. fwd_sel still reports 1 (value invalid, ignored by decode).
- stall_id = load_use | ex_busy.
- issue = id_valid & ~stall_id & ~flush.
- Slot update each clock edge, with rst=0:
  - ex_busy=1: all slots hold; bubble_cnt holds; flush is ignored, and the flush source must keep flush asserted until ex_busy drops.
  - else:
    - WB <= MEM and MEM <= EX.
    - EX <= {issue & id_we & (id_waddr != 0), id_waddr, id_load}.
    - On load_use, EX becomes invalid (bubble).
    - If load_use & ~flush and bubble_cnt != all-ones, bubble_cnt increments. It saturates at all-ones.
- Flush with load_use in the same cycle: flush wins. No bubble is counted and the EX slot is invalid.
- Non-writing instructions (id_we=0) and writes to r0 occupy a slot as invalid.
- rst asserted mid-operation: the next edge clears all slots regardless of ex_busy or flush.

Decomposition:
- Shared package (cpu_defs) holds:
  - FWD_REG/FWD_EX/FWD_MEM/FWD_WB encodings
  - register address width
  - the slot record typedef {valid, waddr, load}
- One natural sub-module: fwd_mux, instanced twice. It is purely combinational: takes one port's match vector and data, and returns sel and data.
- Slot shift and stall logic stay in the top module.

Test Plan:
- ori r1 issued, next instr reads r1 on port 1, ex_wdata=0x1234: fwd_sel1=1, fwd_data1=0x1234, stall_id=0.
- r2 in MEM (mem_wdata=0xA) and in WB (wb_wdata=0xB), port 2 reads r2: fwd_sel2=2, fwd_data2=0xA. With the MEM entry removed: sel=3, data=0xB.
- Load to r3, followed immediately by a read of r3:
  - cycle 1: stall_id=1, issue=0, bubble_cnt 0->1.
  - cycle 2: EX slot invalid, MEM holds the load, fwd_sel=2, stall_id=0.
- Read r0 while EX writes r0 (id_waddr=0): fwd_sel=0, data=reg_data.
- ex_busy held 4 cycles with EX writing r5 and ID reading r5:
  - slots frozen, stall_id=1, fwd_sel=1 throughout.
  - after release, issue=1 and the slots shift.
- Load-use together with flush: stall_id=1, bubble_cnt unchanged. Separately, force bubble_cnt to all-ones plus one more load-use: it stays all-ones. rst mid-stall: all valid bits cleared next cycle and all outputs 0.
